// File: rtl/z16_pkg.sv
// Z16 shared definitions: word width, memory arbiter states
// and requester port ids.
package z16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/z16_prio_arb.sv
// Two-way priority select between fetch and data requesters.
// Data wins ties unless the parent flags fetch as starved.
module z16_prio_arb
    import z16_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic force_if,
    output logic any_req,
    output logic winner
);

    assign any_req = if_req | dm_req;
    assign winner  = (if_req && (!dm_req || force_if)) ? PORT_IF : PORT_DM;

endmodule

// File: rtl/z16_mem_arbiter.sv
// Shares one single-port memory between Z16 fetch and load/store,
// one transaction in flight, data priority with fetch anti-starvation.
module z16_mem_arbiter
    import z16_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [WORD_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [WORD_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [WORD_W-1:0] i_dm_addr,
    input  logic [WORD_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [WORD_W-1:0] o_dm_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [WORD_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic [WORD_W-1:0] i_mem_rdata
);

    localparam logic [2:0] LAT   = 3'(MEM_LAT);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t        state, state_n;
    logic              port_q, port_n;
    logic              we_q, we_n;
    logic [WORD_W-1:0] addr_q, addr_n;
    logic [WORD_W-1:0] wdata_q, wdata_n;
    logic [2:0]        lat_q, lat_n;
    logic [7:0]        starve_q, starve_n;
    logic [WORD_W-1:0] if_rdata_q, dm_rdata_q;
    logic              capture;
    logic              arb_any, arb_win, force_if;

    assign force_if = (STARVE_LIMIT != 0) && (starve_q == LIMIT);

    z16_prio_arb u_arb (
        .if_req   (i_if_req),
        .dm_req   (i_dm_req),
        .force_if (force_if),
        .any_req  (arb_any),
        .winner   (arb_win)
    );

    always_comb begin
        state_n     = state;
        port_n      = port_q;
        we_n        = we_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        lat_n       = lat_q;
        starve_n    = starve_q;
        capture     = 1'b0;
        o_if_gnt    = 1'b0;
        o_dm_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_dm_rvalid = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (state == RESP) begin
                    o_if_rvalid = (port_q == PORT_IF);
                    o_dm_rvalid = (port_q == PORT_DM);
                end
                state_n = IDLE;
                if (arb_any) begin
                    state_n = ISSUE;
                    port_n  = arb_win;
                    if (arb_win == PORT_IF) begin
                        we_n     = 1'b0;
                        addr_n   = i_if_addr;
                        wdata_n  = '0;
                        starve_n = '0;
                    end else begin
                        we_n    = i_dm_we;
                        addr_n  = i_dm_addr;
                        wdata_n = i_dm_wdata;
                        if (i_if_req && starve_q < LIMIT)
                            starve_n = starve_q + 8'd1;
                    end
                end
            end
            ISSUE: begin
                o_mem_en = 1'b1;
                o_mem_we = we_q;
                o_if_gnt = (port_q == PORT_IF);
                o_dm_gnt = (port_q == PORT_DM);
                if (we_q) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                    lat_n   = LAT;
                end
            end
            WAIT: begin
                lat_n = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
        // Nothing may reach the memory or the requesters during reset.
        if (i_rst) begin
            o_if_gnt    = 1'b0;
            o_dm_gnt    = 1'b0;
            o_if_rvalid = 1'b0;
            o_dm_rvalid = 1'b0;
            o_mem_en    = 1'b0;
            o_mem_we    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state    <= state_n;
            port_q   <= port_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            lat_q    <= lat_n;
            starve_q <= starve_n;
            if (capture && port_q == PORT_IF)
                if_rdata_q <= i_mem_rdata;
            if (capture && port_q == PORT_DM)
                dm_rdata_q <= i_mem_rdata;
        end
    end

    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Scoreboard bench for z16_mem_arbiter: instance 0 has MEM_LAT=1,
// STARVE_LIMIT=4; instance 1 has MEM_LAT=3, STARVE_LIMIT=0.
module tb_z16_mem_arbiter;
    import z16_pkg::*;

    localparam int K_MEM = 0;
    localparam int K_IFG = 1;
    localparam int K_DMG = 2;
    localparam int K_IFR = 3;
    localparam int K_DMR = 4;

    typedef struct {
        int          cyc;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [1:0]  if_req = '0, dm_req = '0, dm_we = '0;
    logic [15:0] if_addr [2], dm_addr [2], dm_wdata [2];
    logic [1:0]  if_gnt, if_rv, dm_gnt, dm_rv, mem_en, mem_we;
    logic [15:0] if_rdata [2], dm_rdata [2];
    logic [15:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

    ev_t exp_q [2][5][$];
    int  checks = 0;
    int  errors = 0;

    logic        do_idle = 1'b0, do_hold = 1'b0, do_end = 1'b0;
    int          hold_i = 0;
    logic [15:0] hold_if = '0, hold_dm = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    z16_mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req[0]), .i_if_addr(if_addr[0]),
        .o_if_gnt(if_gnt[0]), .o_if_rvalid(if_rv[0]), .o_if_rdata(if_rdata[0]),
        .i_dm_req(dm_req[0]), .i_dm_we(dm_we[0]), .i_dm_addr(dm_addr[0]),
        .i_dm_wdata(dm_wdata[0]),
        .o_dm_gnt(dm_gnt[0]), .o_dm_rvalid(dm_rv[0]), .o_dm_rdata(dm_rdata[0]),
        .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0])
    );

    z16_mem_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req[1]), .i_if_addr(if_addr[1]),
        .o_if_gnt(if_gnt[1]), .o_if_rvalid(if_rv[1]), .o_if_rdata(if_rdata[1]),
        .i_dm_req(dm_req[1]), .i_dm_we(dm_we[1]), .i_dm_addr(dm_addr[1]),
        .i_dm_wdata(dm_wdata[1]),
        .o_dm_gnt(dm_gnt[1]), .o_dm_rvalid(dm_rv[1]), .o_dm_rdata(dm_rdata[1]),
        .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1])
    );

    // Memory models: word-indexed, read data valid exactly LAT cycles on.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] m  [256];
        logic [15:0] pd [8];
        logic [7:0]  pv;
        always @(posedge clk) begin
            if (rst) begin
                m[2] <= 16'hA5A5;
                m[8] <= 16'h1111;
                m[9] <= 16'h2222;
                pv   <= '0;
            end else begin
                if (mem_en[g] && mem_we[g])
                    m[mem_addr[g][8:1]] <= mem_wdata[g];
                pv    <= {pv[6:0], mem_en[g] && !mem_we[g]};
                pd[0] <= m[mem_addr[g][8:1]];
                for (int j = 1; j < 8; j++) pd[j] <= pd[j-1];
            end
        end
        assign mem_rdata[g] = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;
    end

    function automatic string kname(int k);
        case (k)
            K_MEM:   return "mem_access";
            K_IFG:   return "if_gnt";
            K_DMG:   return "dm_gnt";
            K_IFR:   return "if_rvalid";
            default: return "dm_rvalid";
        endcase
    endfunction

    function automatic void push(int i, int k, int c, logic w,
                                 logic [15:0] a, logic [15:0] d);
        ev_t e;
        e.cyc = c; e.w = w; e.a = a; e.d = d;
        exp_q[i][k].push_back(e);
    endfunction

    function automatic void exp_load(int i, logic port, int iss,
                                     logic [15:0] a, logic [15:0] d, int lat);
        push(i, K_MEM, iss, 1'b0, a, 16'h0);
        push(i, (port == PORT_IF) ? K_IFG : K_DMG, iss, 1'b0, 16'h0, 16'h0);
        push(i, (port == PORT_IF) ? K_IFR : K_DMR, iss + lat + 1, 1'b0, 16'h0, d);
    endfunction

    function automatic void exp_store(int i, int iss, logic [15:0] a, logic [15:0] d);
        push(i, K_MEM, iss, 1'b1, a, d);
        push(i, K_DMG, iss, 1'b0, 16'h0, 16'h0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
        end
    endtask

    task automatic observe(int i, int k, logic w, logic [15:0] a, logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q[i][k].size() == 0) begin
            errors++;
            $display("FAIL unexpected %s[%0d] at cycle %0d: addr=%h data=%h, required none",
                     kname(k), i, cyc, a, d);
        end else begin
            e = exp_q[i][k].pop_front();
            if (e.cyc != cyc || e.w != w || e.a != a ||
                ((k != K_MEM || e.w) && e.d != d)) begin
                errors++;
                $display("FAIL %s[%0d]: got cyc=%0d we=%0b addr=%h data=%h, required cyc=%0d we=%0b addr=%h data=%h",
                         kname(k), i, cyc, w, a, d, e.cyc, e.w, e.a, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i]) observe(i, K_MEM, mem_we[i], mem_addr[i], mem_wdata[i]);
            if (if_gnt[i]) observe(i, K_IFG, 1'b0, 16'h0, 16'h0);
            if (dm_gnt[i]) observe(i, K_DMG, 1'b0, 16'h0, 16'h0);
            if (if_rv[i])  observe(i, K_IFR, 1'b0, 16'h0, if_rdata[i]);
            if (dm_rv[i])  observe(i, K_DMR, 1'b0, 16'h0, dm_rdata[i]);
        end
        if (rst)
            chk("strobes_in_reset", {30'h0, mem_en | mem_we | if_gnt | dm_gnt}, 32'h0);
        if (do_idle) begin
            chk("post_reset_strobes",
                {20'h0, if_gnt, dm_gnt, if_rv, dm_rv, mem_en, mem_we}, 32'h0);
            for (int i = 0; i < 2; i++) begin
                chk("post_reset_rdata", {if_rdata[i], dm_rdata[i]}, 32'h0);
                chk("post_reset_mem_bus", {mem_addr[i], mem_wdata[i]}, 32'h0);
            end
        end
        if (do_hold) begin
            chk("if_rdata_hold", {16'h0, if_rdata[hold_i]}, {16'h0, hold_if});
            chk("dm_rdata_hold", {16'h0, dm_rdata[hold_i]}, {16'h0, hold_dm});
        end
        if (do_end)
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (exp_q[i][k].size() != 0) begin
                        errors++;
                        $display("FAIL missing %s[%0d]: %0d expected events never seen, first at cycle %0d",
                                 kname(k), i, exp_q[i][k].size(), exp_q[i][k][0].cyc);
                    end
                end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_check(int i, logic [15:0] fi, logic [15:0] fd);
        hold_i = i; hold_if = fi; hold_dm = fd; do_hold = 1'b1;
        tick();
        do_hold = 1'b0;
    endtask

    int t;

    initial begin
        for (int i = 0; i < 2; i++) begin
            if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        do_idle = 1'b1;
        tick();
        do_idle = 1'b0;

        // Fetch-only read on A
        t = cyc;
        exp_load(0, PORT_IF, t + 1, 16'h0004, 16'hA5A5, 1);
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        tick(); tick();
        if_req[0] = 1'b0;
        repeat (2) tick();

        // Store then load back on A
        t = cyc;
        exp_store(0, t + 1, 16'h0100, 16'h1234);
        dm_req[0] = 1'b1; dm_we[0] = 1'b1;
        dm_addr[0] = 16'h0100; dm_wdata[0] = 16'h1234;
        tick(); tick();
        dm_we[0] = 1'b0; dm_wdata[0] = 16'h0;
        exp_load(0, PORT_DM, t + 3, 16'h0100, 16'h1234, 1);
        tick(); tick();
        dm_req[0] = 1'b0;
        repeat (2) tick();
        hold_check(0, 16'hA5A5, 16'h1234);

        // Both requests arrive in the RESP cycle of a fetch load on A
        t = cyc;
        exp_load(0, PORT_IF, t + 1, 16'h0004, 16'hA5A5, 1);
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        tick(); tick();
        if_req[0] = 1'b0;
        tick();
        if_req[0] = 1'b1; if_addr[0] = 16'h0012;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0010;
        exp_load(0, PORT_DM, t + 4, 16'h0010, 16'h1111, 1);
        exp_load(0, PORT_IF, t + 7, 16'h0012, 16'h2222, 1);
        tick(); tick();
        dm_req[0] = 1'b0;
        repeat (3) tick();
        if_req[0] = 1'b0;
        repeat (2) tick();

        // Both held continuously on A: DM x4 then IF, twice
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        dm_req[0] = 1'b1; dm_we[0] = 1'b1;
        dm_addr[0] = 16'h0020; dm_wdata[0] = 16'h5555;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                exp_store(0, t + 11 * r + 1 + 2 * k, 16'h0020, 16'h5555);
            exp_load(0, PORT_IF, t + 11 * r + 9, 16'h0004, 16'hA5A5, 1);
        end
        while (cyc < t + 19) tick();
        dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        while (cyc < t + 21) tick();
        if_req[0] = 1'b0;
        repeat (3) tick();
        hold_check(0, 16'hA5A5, 16'h1111);

        // Pure data priority on B: fetch waits until data goes away
        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 16'h0004;
        dm_req[1] = 1'b1; dm_we[1] = 1'b1;
        dm_addr[1] = 16'h0020; dm_wdata[1] = 16'h7777;
        for (int k = 0; k < 5; k++)
            exp_store(1, t + 1 + 2 * k, 16'h0020, 16'h7777);
        exp_load(1, PORT_IF, t + 11, 16'h0004, 16'hA5A5, 3);
        while (cyc < t + 10) tick();
        dm_req[1] = 1'b0; dm_we[1] = 1'b0;
        while (cyc < t + 12) tick();
        if_req[1] = 1'b0;
        while (cyc < t + 17) tick();

        // Back-to-back data loads on B (MEM_LAT=3)
        t = cyc;
        dm_req[1] = 1'b1; dm_we[1] = 1'b0;
        dm_addr[1] = 16'h0010; dm_wdata[1] = 16'h0;
        exp_load(1, PORT_DM, t + 1, 16'h0010, 16'h1111, 3);
        exp_load(1, PORT_DM, t + 6, 16'h0012, 16'h2222, 3);
        tick(); tick();
        dm_addr[1] = 16'h0012;
        while (cyc < t + 7) tick();
        dm_req[1] = 1'b0;
        while (cyc < t + 12) tick();
        hold_check(1, 16'hA5A5, 16'h2222);

        // Reset lands on the ISSUE cycle of a fetch on A
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        tick();
        rst = 1'b1; if_req[0] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Reset during WAIT of a fetch load on B
        t = cyc;
        push(1, K_MEM, t + 1, 1'b0, 16'h0012, 16'h0);
        push(1, K_IFG, t + 1, 1'b0, 16'h0, 16'h0);
        if_req[1] = 1'b1; if_addr[1] = 16'h0012;
        tick(); tick();
        if_req[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_idle = 1'b1;
        tick();
        do_idle = 1'b0;
        repeat (8) tick();

        do_end = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
